// File: rtl/kyber_poly_add_stream.sv
// Streaming lane-parallel adder for Kyber encapsulation: u[k] = x[k] + e1[k], then v = y + e2 + m.
// Define KYBER_ADD_REDUCE_EN to reduce every sum into [0, Q-1]; otherwise raw unsigned sums are emitted.
module kyber_poly_add_stream #(
    parameter int K     = 3,
    parameter int N     = 256,
    parameter int LANES = 8,
    parameter int Q     = 3329,
    parameter int CW    = 12,
    parameter int EW    = 3,
`ifdef KYBER_ADD_REDUCE_EN
    localparam int OW   = CW
`else
    localparam int OW   = CW + 2
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*CW-1:0]   a_coeffs,
    input  logic [LANES*EW-1:0]   e_coeffs,
    input  logic [LANES*CW-1:0]   m_coeffs,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*OW-1:0]   out_coeffs,
    output logic [2:0]            out_poly,
    output logic                  out_last,
    output logic                  err
);
    localparam int BEATS = N / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW    = CW + 4;
    localparam logic [BW-1:0]        LAST_BEAT = BW'(BEATS - 1);
    localparam logic signed [SW-1:0] QS        = SW'(Q);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   beat_cnt;
    logic [2:0]      poly_cnt;
    logic            in_fire, out_fire, is_v, last_in;
    logic [LANES*OW-1:0] sum_p0;
    logic            bad_p0;

    // Legal small coefficients are -2..+2 once sign-extended.
    function automatic logic e_illegal(input logic [EW-1:0] e);
        logic signed [15:0] ev;
        ev = {{(16-EW){e[EW-1]}}, e};
        return (ev > 16'sd2) || (ev < -16'sd2);
    endfunction

`ifdef KYBER_ADD_REDUCE_EN
    function automatic logic [OW-1:0] lane_sum(input logic [CW-1:0] a, input logic [EW-1:0] e,
                                               input logic [CW-1:0] m);
        logic signed [SW-1:0] ev;
        logic signed [SW-1:0] s;
        ev = e_illegal(e) ? '0 : {{(SW-EW){e[EW-1]}}, e};
        s  = $signed(SW'(a)) + ev + $signed(SW'(m));
        if (s[SW-1]) s = s + QS;
        if (s >= QS) s = s - QS;
        if (s >= QS) s = s - QS;
        return s[OW-1:0];
    endfunction
`else
    // Negative e' is folded into the unsigned path as Q-1 / Q-2.
    function automatic logic [OW-1:0] lane_sum(input logic [CW-1:0] a, input logic [EW-1:0] e,
                                               input logic [CW-1:0] m);
        logic signed [SW-1:0] ev;
        logic [OW-1:0]        eadd;
        ev   = e_illegal(e) ? '0 : {{(SW-EW){e[EW-1]}}, e};
        eadd = OW'(ev[SW-1] ? QS + ev : ev);
        return OW'(a) + eadd + OW'(m);
    endfunction
`endif

    assign is_v     = (poly_cnt == 3'(K));
    assign last_in  = is_v && (beat_cnt == LAST_BEAT);
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign busy     = (state != IDLE);

    // Stage p0: combinational lane sums of the presented beat
    always_comb begin
        sum_p0 = '0;
        bad_p0 = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            sum_p0[i*OW +: OW] = lane_sum(a_coeffs[i*CW +: CW], e_coeffs[i*EW +: EW],
                                          is_v ? m_coeffs[i*CW +: CW] : '0);
            bad_p0 = bad_p0 | e_illegal(e_coeffs[i*EW +: EW]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (in_fire && last_in) state_nxt = FLUSH;
            FLUSH:   if (out_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: single-entry output register plus job counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            poly_cnt   <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_coeffs <= '0;
            out_poly   <= '0;
            out_last   <= 1'b0;
        end else begin
            done <= (state == FLUSH) && out_fire;
            if (state == IDLE && start) begin
                beat_cnt <= '0;
                poly_cnt <= '0;
                err      <= 1'b0;
            end else if (in_fire) begin
                if (bad_p0) err <= 1'b1;
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt <= '0;
                    if (!is_v) poly_cnt <= poly_cnt + 3'd1;
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end
            if (in_fire) begin
                out_valid  <= 1'b1;
                out_coeffs <= sum_p0;
                out_poly   <= poly_cnt;
                out_last   <= last_in;
            end else if (out_fire) begin
                out_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_kyber_poly_add_stream.sv
// Directed bench for kyber_poly_add_stream: table of hand-computed lane vectors plus stall/abort sequences.
module tb_kyber_poly_add_stream;
    localparam int K = 3, N = 256, LANES = 8, Q = 3329, CW = 12, EW = 3;
    localparam int BEATS = N / LANES;
    localparam int TOTAL = BEATS * (K + 1);
`ifdef KYBER_ADD_REDUCE_EN
    localparam int OW = CW;
`else
    localparam int OW = CW + 2;
`endif

    logic clk = 1'b0;
    logic rst_n, start, busy, done, in_valid, in_ready, out_valid, out_ready, out_last, err;
    logic [LANES*CW-1:0] a_coeffs, m_coeffs;
    logic [LANES*EW-1:0] e_coeffs;
    logic [LANES*OW-1:0] out_coeffs;
    logic [2:0]          out_poly;

    always #5 clk = ~clk;

    kyber_poly_add_stream #(.K(K), .N(N), .LANES(LANES), .Q(Q), .CW(CW), .EW(EW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .a_coeffs(a_coeffs), .e_coeffs(e_coeffs),
        .m_coeffs(m_coeffs), .out_valid(out_valid), .out_ready(out_ready), .out_coeffs(out_coeffs),
        .out_poly(out_poly), .out_last(out_last), .err(err)
    );

    typedef struct {
        int    poly;
        int    beat;
        int    lane;
        int    a;
        int    e;
        int    m;
        int    exp_raw;
        int    exp_red;
        string name;
    } vec_t;

    typedef struct {
        logic [LANES*OW-1:0] c;
        logic [2:0]          p;
        logic                l;
        int                  idx;
    } beat_t;

    vec_t  vecs[12];
    beat_t q[$];
    int    n_checks, n_pass;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [LANES*OW-1:0] act, input logic [LANES*OW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int exp_of(input vec_t v);
`ifdef KYBER_ADD_REDUCE_EN
        return v.exp_red;
`else
        return v.exp_raw;
`endif
    endfunction

    task automatic build_beat(input int idx, input bit use_tbl, output logic [LANES*CW-1:0] a,
                              output logic [LANES*EW-1:0] e, output logic [LANES*CW-1:0] m,
                              output logic [LANES*OW-1:0] x);
        int poly;
        int beat;
        int ln;
        poly = idx / BEATS;
        beat = idx % BEATS;
        a = '0; e = '0; m = '0; x = '0;
        if (use_tbl && poly < K)
            for (int l = 0; l < LANES; l++) m[l*CW +: CW] = 12'h5A5;
        if (use_tbl)
            foreach (vecs[i])
                if (vecs[i].poly == poly && vecs[i].beat == beat && exp_of(vecs[i]) >= 0) begin
                    ln = vecs[i].lane;
                    a[ln*CW +: CW] = CW'(vecs[i].a);
                    e[ln*EW +: EW] = EW'(vecs[i].e);
                    m[ln*CW +: CW] = CW'(vecs[i].m);
                    x[ln*OW +: OW] = OW'(exp_of(vecs[i]));
                end
    endtask

    task automatic run_job(input bit use_tbl, input int stall_at, input int abort_at);
        int sent, got, cyc, stall_left;
        bit stalled, poked;
        logic [LANES*CW-1:0] a, m;
        logic [LANES*EW-1:0] e;
        logic [LANES*OW-1:0] x;
        beat_t b, h;
        sent = 0; got = 0; cyc = 0; stall_left = 0; stalled = 0; poked = 0;
        q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk1("busy_after_start", busy, 1'b1);
        chk1("err_cleared_on_start", err, 1'b0);
        while (got < TOTAL && cyc < 1000) begin
            if (abort_at >= 0 && sent == abort_at) begin
                rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
                @(negedge clk);
                chk1("abort_busy", busy, 1'b0);
                chk1("abort_out_valid", out_valid, 1'b0);
                chk1("abort_in_ready", in_ready, 1'b0);
                chk1("abort_out_last", out_last, 1'b0);
                chkw("abort_coeffs", out_coeffs, '0);
                chki("abort_poly", int'(out_poly), 0);
                rst_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk1("abort_no_done", done, 1'b0);
                end
                chk1("abort_idle", busy, 1'b0);
                return;
            end
            if (stall_at >= 0 && sent == stall_at && !stalled) begin
                stalled = 1'b1;
                stall_left = 5;
            end
            start = use_tbl && sent == 50 && !poked;
            if (start) poked = 1'b1;
            build_beat(sent, use_tbl, a, e, m, x);
            in_valid  = (sent < TOTAL);
            a_coeffs  = a;
            e_coeffs  = e;
            m_coeffs  = m;
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                chk1("stall_in_ready", in_ready, 1'b0);
                chk1("stall_out_valid", out_valid, 1'b1);
                if (q.size() > 0) chkw("stall_hold", out_coeffs, q[0].c);
                stall_left--;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk1("spurious_beat", out_valid, 1'b0);
                end else begin
                    h = q.pop_front();
                    chkw($sformatf("coeffs_%0d", h.idx), out_coeffs, h.c);
                    chki($sformatf("poly_last_%0d", h.idx), int'({out_poly, out_last}), int'({h.p, h.l}));
                    if (use_tbl) begin
                        foreach (vecs[i])
                            if (vecs[i].poly * BEATS + vecs[i].beat == h.idx && exp_of(vecs[i]) >= 0)
                                chki(vecs[i].name, int'(out_coeffs[vecs[i].lane*OW +: OW]), exp_of(vecs[i]));
                        if (h.idx == 6) chk1("err_before_bad", err, 1'b0);
                        if (h.idx == 7) chk1("err_at_bad", err, 1'b1);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                b.c = x;
                b.p = 3'(sent / BEATS);
                b.l = (sent == TOTAL - 1);
                b.idx = sent;
                q.push_back(b);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chki("beats_out", got, TOTAL);
        chki("queue_empty", q.size(), 0);
        chk1("done_pulse", done, 1'b1);
        chk1("busy_at_done", busy, 1'b0);
        chk1("out_valid_after", out_valid, 1'b0);
        @(negedge clk);
        chk1("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_coeffs = '0; e_coeffs = '0; m_coeffs = '0;
        vecs[0]  = '{0, 0, 0, 3328, 1, 0, 3329, 0, "u_a_max_plus1"};
        vecs[1]  = '{0, 0, 1, 0, 7, 0, 3328, 3328, "u_zero_minus1"};
        vecs[2]  = '{0, 1, 2, 3328, 7, 0, 6656, 3327, "u_max_minus1"};
        vecs[3]  = '{0, 1, 5, 100, 6, 0, 3427, 98, "u_minus2"};
        vecs[4]  = '{0, 7, 3, 1234, 4, 0, 1234, 1234, "u_illegal_e"};
        vecs[5]  = '{1, 3, 0, 5, 2, 777, 7, 7, "u_m_ignored"};
        vecs[6]  = '{1, 31, 0, 4095, 2, 0, 4097, -1, "u_wide_a"};
        vecs[7]  = '{2, 31, 7, 1, 6, 0, 3328, 3328, "u_neg_wrap"};
        vecs[8]  = '{3, 0, 0, 3328, 2, 3328, 6658, 0, "v_max_sum"};
        vecs[9]  = '{3, 0, 1, 4095, 6, 4095, 11517, -1, "v_wide_minus2"};
        vecs[10] = '{3, 10, 4, 2000, 1, 1500, 3501, 172, "v_mid"};
        vecs[11] = '{3, 31, 7, 0, 7, 0, 3328, 3328, "v_last_minus1"};

        repeat (3) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chkw("rst_coeffs", out_coeffs, '0);
        chki("rst_poly", int'(out_poly), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("idle_in_ready", in_ready, 1'b0);

        run_job(1'b0, -1, -1);
        run_job(1'b1, 42, -1);
        @(negedge clk);
        chk1("err_sticky_idle", err, 1'b1);
        run_job(1'b0, -1, 3 * BEATS + 10);
        run_job(1'b0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
